// File: rtl/alu.sv
// Registered 32-bit RV32I integer ALU for the execute stage.
// One-cycle latency; result and zero flag come from the same combinational value.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        zero_flag
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_t;

  logic [31:0] result_next;
  logic [4:0]  shamt;
  logic        lt_signed;
  logic        lt_unsigned;

  assign shamt       = in2[4:0];
  // Direct signed compare keeps SLT correct when in1 - in2 overflows.
  assign lt_signed   = $signed(in1) < $signed(in2);
  assign lt_unsigned = in1 < in2;

  always_comb begin
    result_next = 32'h0000_0000;
    case (alu_control)
      OP_AND:  result_next = in1 & in2;
      OP_OR:   result_next = in1 | in2;
      OP_ADD:  result_next = in1 + in2;
      OP_XOR:  result_next = in1 ^ in2;
      OP_SUB:  result_next = in1 - in2;
      OP_SLL:  result_next = in1 << shamt;
      OP_SRL:  result_next = in1 >> shamt;
      OP_SRA:  result_next = $unsigned($signed(in1) >>> shamt);
      OP_SLT:  result_next = {31'b0, lt_signed};
      OP_SLTU: result_next = {31'b0, lt_unsigned};
      default: result_next = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result <= 32'h0000_0000;
      zero_flag  <= 1'b1;
    end else begin
      alu_result <= result_next;
      zero_flag  <= (result_next == 32'h0000_0000);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
// Each scenario task drives vectors and checks results one cycle later.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero_flag;

  int checks;
  int failures;

  alu dut (
    .clk(clk),
    .rst_n(rst_n),
    .in1(in1),
    .in2(in2),
    .alu_control(alu_control),
    .alu_result(alu_result),
    .zero_flag(zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, clock it in, and settle just after the edge.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    rst_n       = r;
    in1         = a;
    in2         = b;
    alu_control = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 32'd23, 32'd42, 4'b0010);
    checks++;
    if (alu_result !== 32'h0 || zero_flag !== 1'b1) begin
      failures++;
      $display("FAIL reset_edge1 got result=%h zero=%b need result=00000000 zero=1", alu_result, zero_flag);
    end
    step(1'b0, 32'd23, 32'd42, 4'b0010);
    checks++;
    if (alu_result !== 32'h0 || zero_flag !== 1'b1) begin
      failures++;
      $display("FAIL reset_edge2 got result=%h zero=%b need result=00000000 zero=1", alu_result, zero_flag);
    end
    step(1'b1, 32'd23, 32'd42, 4'b0010);
    checks++;
    if (alu_result !== 32'd65 || zero_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got result=%h zero=%b need result=00000041 zero=0", alu_result, zero_flag);
    end
    $display("reset: 2 edges held, first op after release checked");
  endtask

  task automatic test_logic_add();
    logic [3:0]  ops [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
    logic [31:0] exp [4] = '{32'd2, 32'd63, 32'd65, 32'd61};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'd23, 32'd42, ops[i]);
      checks++;
      if (alu_result !== exp[i] || zero_flag !== 1'b0) begin
        failures++;
        $display("FAIL logic_add op=%b got result=%h zero=%b need result=%h zero=0",
                 ops[i], alu_result, zero_flag, exp[i]);
      end
      $display("logic_add: op=%b result=%h zero=%b", ops[i], alu_result, zero_flag);
    end
  endtask

  task automatic test_sub_compare();
    logic [31:0] a   [5] = '{32'd23, 32'd42, 32'd23, 32'd42, 32'd23};
    logic [31:0] b   [5] = '{32'd42, 32'd23, 32'd42, 32'd23, 32'd23};
    logic [3:0]  ops [5] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0100};
    logic [31:0] exp [5] = '{32'hFFFF_FFED, 32'd19, 32'd1, 32'd0, 32'd0};
    logic        ez  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, a[i], b[i], ops[i]);
      checks++;
      if (alu_result !== exp[i] || zero_flag !== ez[i]) begin
        failures++;
        $display("FAIL sub_compare %0d op=%b got result=%h zero=%b need result=%h zero=%b",
                 i, ops[i], alu_result, zero_flag, exp[i], ez[i]);
      end
      $display("sub_compare: a=%h b=%h op=%b result=%h zero=%b", a[i], b[i], ops[i], alu_result, zero_flag);
    end
  endtask

  task automatic test_signed_unsigned();
    logic [31:0] a   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [3:0]  ops [3] = '{4'b1000, 4'b1001, 4'b1000};
    logic [31:0] exp [3] = '{32'd1, 32'd0, 32'd1};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, a[i], 32'd1, ops[i]);
      checks++;
      if (alu_result !== exp[i] || zero_flag !== (exp[i] == 32'd0)) begin
        failures++;
        $display("FAIL signed_unsigned %0d op=%b got result=%h zero=%b need result=%h",
                 i, ops[i], alu_result, zero_flag, exp[i]);
      end
      $display("signed_unsigned: a=%h op=%b result=%h zero=%b", a[i], ops[i], alu_result, zero_flag);
    end
  endtask

  task automatic test_shifts();
    logic [31:0] b   [4] = '{32'd4, 32'd4, 32'd4, 32'h24};
    logic [3:0]  ops [4] = '{4'b0101, 4'b0110, 4'b0111, 4'b0110};
    logic [31:0] exp [4] = '{32'h0000_0100, 32'h0800_0001, 32'hF800_0001, 32'h0800_0001};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h8000_0010, b[i], ops[i]);
      checks++;
      if (alu_result !== exp[i] || zero_flag !== 1'b0) begin
        failures++;
        $display("FAIL shifts %0d op=%b got result=%h zero=%b need result=%h zero=0",
                 i, ops[i], alu_result, zero_flag, exp[i]);
      end
      $display("shifts: b=%h op=%b result=%h zero=%b", b[i], ops[i], alu_result, zero_flag);
    end
  endtask

  task automatic test_hold();
    step(1'b1, 32'd42, 32'd23, 4'b0100);
    in1         = 32'd1;
    in2         = 32'd1;
    alu_control = 4'b0010;
    #3;
    checks++;
    if (alu_result !== 32'd19 || zero_flag !== 1'b0) begin
      failures++;
      $display("FAIL hold_between_edges got result=%h zero=%b need result=00000013 zero=0", alu_result, zero_flag);
    end
    @(posedge clk);
    #1;
    checks++;
    if (alu_result !== 32'd2 || zero_flag !== 1'b0) begin
      failures++;
      $display("FAIL hold_next_edge got result=%h zero=%b need result=00000002 zero=0", alu_result, zero_flag);
    end
    $display("hold: outputs stable between edges, late inputs taken at next edge");
  endtask

  task automatic test_reserved_and_reset();
    step(1'b1, 32'd23, 32'd42, 4'b1111);
    checks++;
    if (alu_result !== 32'h0 || zero_flag !== 1'b1) begin
      failures++;
      $display("FAIL reserved got result=%h zero=%b need result=00000000 zero=1", alu_result, zero_flag);
    end
    $display("reserved: op=1111 result=%h zero=%b", alu_result, zero_flag);
    step(1'b1, 32'd23, 32'd42, 4'b1010);
    checks++;
    if (alu_result !== 32'h0 || zero_flag !== 1'b1) begin
      failures++;
      $display("FAIL reserved_1010 got result=%h zero=%b need result=00000000 zero=1", alu_result, zero_flag);
    end
    step(1'b1, 32'd23, 32'd42, 4'b0010);
    checks++;
    if (alu_result !== 32'd65 || zero_flag !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_add got result=%h zero=%b need result=00000041 zero=0", alu_result, zero_flag);
    end
    step(1'b0, 32'd23, 32'd42, 4'b0010);
    checks++;
    if (alu_result !== 32'h0 || zero_flag !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_flight got result=%h zero=%b need result=00000000 zero=1", alu_result, zero_flag);
    end
    $display("reset_in_flight: result=%h zero=%b", alu_result, zero_flag);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    in1         = 32'd0;
    in2         = 32'd0;
    alu_control = 4'b0000;
    test_reset();
    test_logic_add();
    test_sub_compare();
    test_signed_unsigned();
    test_shifts();
    test_hold();
    test_reserved_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
